// File: rtl/csel_sub32_pipe_if.sv
// Operand/result stream bundle for csel_sub32_pipe.
// Handshake: a beat moves on a rising edge only when valid && ready are both high;
// a producer holds valid and data steady until that edge, and ready never depends on valid.
interface csel_sub32_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow;
    logic        zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, zero
    );
endinterface

// File: rtl/csel_sub32_pipe.sv
// Two-stage carry-select 32-bit unsigned subtractor (diff = a - b, borrow, zero).
// Optional build macro CSEL_SUB_SAT_EN: saturate diff to 0 whenever a borrow occurs.
module csel_sub32_pipe (
    input  logic               clk,
    input  logic               rst_n,
    csel_sub32_pipe_if.slave   bus
);

    logic        s1_valid;
    logic        s1_en;
    logic        s2_en;
    logic [15:0] s1_lo;
    logic [15:0] s1_up0;
    logic [15:0] s1_up1;
    logic        s1_c_lo;
    logic        s1_c0;
    logic        s1_c1;

    logic [16:0] lo_sum;
    logic [16:0] up0_sum;
    logic [16:0] up1_sum;

    logic [31:0] sel_diff;
    logic        sel_borrow;
    logic        sel_zero;

    logic        out_valid_q;
    logic [31:0] diff_q;
    logic        borrow_q;
    logic        zero_q;

    // Pipeline advances on an empty or draining slot; ready is a function of state only.
    assign s2_en        = !out_valid_q || bus.out_ready;
    assign s1_en        = !s1_valid || s2_en;
    assign bus.in_ready = s1_en;

    // a - b as a + ~b + 1; carry-out of 1 means no borrow.
    always_comb begin
        lo_sum  = {1'b0, bus.a[15:0]}  + {1'b0, ~bus.b[15:0]}  + 17'd1;
        up0_sum = {1'b0, bus.a[31:16]} + {1'b0, ~bus.b[31:16]};
        up1_sum = {1'b0, bus.a[31:16]} + {1'b0, ~bus.b[31:16]} + 17'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_lo    <= 16'd0;
            s1_up0   <= 16'd0;
            s1_up1   <= 16'd0;
            s1_c_lo  <= 1'b0;
            s1_c0    <= 1'b0;
            s1_c1    <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_lo   <= lo_sum[15:0];
                s1_c_lo <= lo_sum[16];
                s1_up0  <= up0_sum[15:0];
                s1_c0   <= up0_sum[16];
                s1_up1  <= up1_sum[15:0];
                s1_c1   <= up1_sum[16];
            end
        end
    end

    // Lower carry picks which precomputed upper half is the real one.
    always_comb begin
        sel_diff   = {s1_up0, s1_lo};
        sel_borrow = ~s1_c0;
        if (s1_c_lo) begin
            sel_diff   = {s1_up1, s1_lo};
            sel_borrow = ~s1_c1;
        end
`ifdef CSEL_SUB_SAT_EN
        if (sel_borrow) begin
            sel_diff = 32'd0;
        end
`endif
        sel_zero = (sel_diff == 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            diff_q      <= 32'd0;
            borrow_q    <= 1'b0;
            zero_q      <= 1'b0;
        end else if (s2_en) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                diff_q   <= sel_diff;
                borrow_q <= sel_borrow;
                zero_q   <= sel_zero;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.zero      = zero_q;

endmodule
